izh_scheduler: RTL and testbench

Time-multiplexes one Izhikevich neuron update datapath across `N` virtual neurons. Each `tick` pulse advances every neuron one Euler step, in index order. Per-neuron state (v, u) and input currents are held in local register files. Spike events go out through a small FIFO with a valid/ready handshake. The block sits between the host configuration interface and the spike router, and replaces per-neuron instances of the single-neuron model.

---
 rtl/izh_pkg.sv | 38 +++
 rtl/izh_step.sv | 47 ++++
 rtl/izh_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_izh_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared types and constants for the time-multiplexed Izhikevich neuron datapath.
// All neuron quantities are Q9.7 signed 16-bit values.
package izh_pkg;

   localparam int QW = 16;
   typedef logic signed [QW-1:0] q_t;

   // Model constants in Q9.7
   localparam int A    = 26;      // 0.2
   localparam int B    = 26;      // 0.2
   localparam int C    = -8320;   // -65 mV reset potential
   localparam int D    = 1024;    // 8, recovery bump after a spike
   localparam int VTH  = 3840;    // 30 mV spike threshold
   localparam int K2   = 5;       // ~0.04 quadratic coefficient
   localparam int K140 = 17920;   // 140

   localparam int QMAX = 32767;
   localparam int QMIN = -32768;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_STALL
   } state_e;

   // Clamp a 32-bit intermediate into the Q9.7 range
   function automatic q_t sat(input logic signed [31:0] x);
      if (x > QMAX) begin
         return q_t'(QMAX);
      end else if (x < QMIN) begin
         return q_t'(QMIN);
      end else begin
         return q_t'(x);
      end
   endfunction

endpackage

// File: rtl/izh_step.sv
// One Euler step of the Izhikevich model: (v, u, I) -> (v', u', spike).
// Purely combinational; shared with the single-neuron model.
module izh_step
   import izh_pkg::*;
#(
   parameter int DT_SHIFT = 2
) (
   input  logic signed [QW-1:0] v_i,
   input  logic signed [QW-1:0] u_i,
   input  logic [7:0]           cur_i,
   output logic signed [QW-1:0] v_o,
   output logic signed [QW-1:0] u_o,
   output logic                 spike_o
);

   logic signed [31:0] v32, u32, i32;
   logic signed [31:0] v2, k2v2, dv, bv, du;
   logic signed [31:0] v_sum, u_sum, u_reset;

   assign v32 = {{(32-QW){v_i[QW-1]}}, v_i};
   assign u32 = {{(32-QW){u_i[QW-1]}}, u_i};
   // Integer mA current placed at the Q9.7 binary point
   assign i32 = $signed({17'd0, cur_i, 7'd0});

   assign v2      = (v32 * v32) >>> 7;
   assign k2v2    = (K2 * v2) >>> 7;
   assign dv      = k2v2 + 5 * v32 + K140 - u32 + i32;
   assign bv      = (B * v32) >>> 7;
   assign du      = (A * (bv - u32)) >>> 7;
   assign v_sum   = v32 + (dv >>> DT_SHIFT);
   assign u_sum   = u32 + (du >>> DT_SHIFT);
   assign u_reset = u32 + D;

   // Select between the spike/reset path and the integration path
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      spike_o = 1'b0;
      v_o     = sat(v_sum);
      u_o     = sat(u_sum);
      if (v32 >= VTH) begin
         spike_o = 1'b1;
         v_o     = q_t'(C);
         u_o     = sat(u_reset);
      end
   end

endmodule

// File: rtl/izh_scheduler.sv
// Time-multiplexes one izh_step datapath over N virtual neurons.
// Each tick sweeps all neurons in index order (READ then WRITE per neuron);
// spikes leave through a small valid/ready FIFO and are never dropped.
module izh_scheduler
   import izh_pkg::*;
#(
   parameter int N          = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DT_SHIFT   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 cfg_we,
   input  logic [$clog2(N)-1:0] cfg_addr,
   input  logic [7:0]           cfg_current,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [$clog2(N)-1:0] ev_id,
   output logic [7:0]           ev_time
);

   localparam int IW = $clog2(N);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = FW + 1;

   // Sequencer state
   state_e          state_q;
   logic [IW-1:0]   idx_q;
   logic [7:0]      sweep_q;
   logic            pending_q;
   logic            overrun_q;
   logic            busy_q;

   // Per-neuron register files
   q_t              v_q   [N];
   q_t              u_q   [N];
   logic [7:0]      cur_q [N];

   // Operand register between READ and WRITE
   q_t              pv_q;
   q_t              pu_q;
   logic [7:0]      pi_q;

   // Step results
   q_t              v_nxt;
   q_t              u_nxt;
   logic            spike;

   // Event FIFO
   logic [IW-1:0]   fifo_id_q   [FIFO_DEPTH];
   logic [7:0]      fifo_time_q [FIFO_DEPTH];
   logic [FW-1:0]   wr_ptr_q;
   logic [FW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;

   logic            fifo_full;
   logic            commit;
   logic            push;
   logic            pop;
   logic            last;

   izh_step #(
      .DT_SHIFT (DT_SHIFT)
   ) u_step (
      .v_i     (pv_q),
      .u_i     (pu_q),
      .cur_i   (pi_q),
      .v_o     (v_nxt),
      .u_o     (u_nxt),
      .spike_o (spike)
   );

   // A write commits unless it carries a spike that has nowhere to go
   assign fifo_full = (count_q == CW'(FIFO_DEPTH));
   assign commit    = ((state_q == ST_WRITE) || (state_q == ST_STALL)) && !(spike && fifo_full);
   assign push      = commit && spike;
   assign pop       = (count_q != '0) && ev_ready;
   assign last      = (idx_q == IW'(N - 1));

   // Sweep sequencer, tick bookkeeping and operand fetch
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         sweep_q   <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         pv_q      <= q_t'(C);
         pu_q      <= '0;
         pi_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick || pending_q) begin
                  state_q   <= ST_READ;
                  idx_q     <= '0;
                  busy_q    <= 1'b1;
                  // A tick landing together with a consumed pending request stays queued
                  pending_q <= pending_q && tick;
               end
            end
            ST_READ: begin
               pv_q    <= v_q[idx_q];
               pu_q    <= u_q[idx_q];
               pi_q    <= cur_q[idx_q];
               state_q <= ST_WRITE;
            end
            ST_WRITE, ST_STALL: begin
               if (commit) begin
                  if (last) begin
                     sweep_q <= sweep_q + 8'd1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     idx_q   <= idx_q + IW'(1);
                     state_q <= ST_READ;
                  end
               end else begin
                  state_q <= ST_STALL;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (tick && (state_q != ST_IDLE)) begin
            if (pending_q) begin
               overrun_q <= 1'b1;
            end else begin
               pending_q <= 1'b1;
            end
         end
      end
   end

   // Neuron state write-back and host current writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            v_q[i]   <= q_t'(C);
            u_q[i]   <= '0;
            cur_q[i] <= '0;
         end
      end else begin
         if (commit) begin
            v_q[idx_q] <= v_nxt;
            u_q[idx_q] <= u_nxt;
         end
         if (cfg_we) begin
            cur_q[cfg_addr] <= cfg_current;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + FW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      // NOTE: payload slots are not reset; they are only read once count_q marks them valid.
      if (push) begin
         fifo_id_q[wr_ptr_q]   <= idx_q;
         fifo_time_q[wr_ptr_q] <= sweep_q;
      end
   end

   assign busy     = busy_q;
   // Decoded from registered state so it coincides with the committing final write
   assign done     = commit && last;
   assign overrun  = overrun_q;
   assign ev_valid = (count_q != '0);
   assign ev_id    = fifo_id_q[rd_ptr_q];
   assign ev_time  = fifo_time_q[rd_ptr_q];

endmodule

// File: tb/tb_izh_scheduler.sv
// Directed bench for izh_scheduler (N=4, FIFO_DEPTH=4, DT_SHIFT=2).
module tb_izh_scheduler;
   import izh_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       tick;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_current;
   logic       busy;
   logic       done;
   logic       overrun;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_id;
   logic [7:0] ev_time;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state
   int mv [4];
   int mu [4];
   int mcur [4];
   int msweep;
   bit mspk [4];
   int exp_id [$];
   int exp_time [$];
   int n_pushed;
   int n_seen;

   izh_scheduler #(
      .N          (4),
      .FIFO_DEPTH (4),
      .DT_SHIFT   (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_current (cfg_current),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_id       (ev_id),
      .ev_time     (ev_time)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int msat(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   task automatic model_step(input int v, input int u, input int cur,
                             output int vn, output int un, output bit sp);
      int v2, dv, du;
      if (v >= 3840) begin
         vn = -8320;
         un = msat(u + 1024);
         sp = 1'b1;
      end else begin
         v2 = (v * v) >>> 7;
         dv = ((5 * v2) >>> 7) + 5 * v + 17920 - u + (cur * 128);
         du = (26 * (((26 * v) >>> 7) - u)) >>> 7;
         vn = msat(v + (dv >>> 2));
         un = msat(u + (du >>> 2));
         sp = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mv[i]   = -8320;
         mu[i]   = 0;
         mcur[i] = 0;
      end
      msweep = 0;
      exp_id.delete();
      exp_time.delete();
   endtask

   task automatic model_sweep();
      int vn, un;
      bit sp;
      for (int i = 0; i < 4; i++) begin
         model_step(mv[i], mu[i], mcur[i], vn, un, sp);
         mv[i]   = vn;
         mu[i]   = un;
         mspk[i] = sp;
         if (sp) begin
            exp_id.push_back(i);
            exp_time.push_back(msweep);
            n_pushed++;
         end
      end
      msweep = (msweep + 1) % 256;
   endtask

   task automatic compare_state(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_v%0d", tag, i), dut.v_q[i], mv[i]);
         chk($sformatf("%s_u%0d", tag, i), dut.u_q[i], mu[i]);
      end
   endtask

   // Score an event handshake about to happen on the next edge
   task automatic watch();
      if (ev_valid && ev_ready) begin
         n_seen++;
         chk("ev_expected", int'(exp_id.size() > 0), 1);
         if (exp_id.size() > 0) begin
            chk("ev_id", ev_id, exp_id.pop_front());
            chk("ev_time", ev_time, exp_time.pop_front());
         end
      end
   endtask

   task automatic set_cur(input int idx, input int val);
      cfg_we      = 1'b1;
      cfg_addr    = 2'(idx);
      cfg_current = 8'(val);
      step();
      cfg_we      = 1'b0;
      mcur[idx]   = val;
   endtask

   // Tick, follow the sweep to done, then let trailing events drain
   task automatic run_sweep(input string tag, output int done_cyc);
      int cyc;
      model_sweep();
      tick = 1'b1;
      step();
      tick = 1'b0;
      cyc = 1;
      chk({tag, "_busy_c1"}, busy, 1);
      chk({tag, "_idx_c1"}, dut.idx_q, 0);
      while (!done && cyc < 200) begin
         watch();
         step();
         cyc++;
      end
      chk({tag, "_done_seen"}, done, 1);
      done_cyc = cyc;
      watch();
      step();
      chk({tag, "_idle_after"}, busy, 0);
      repeat (4) begin
         watch();
         step();
      end
   endtask

   initial begin
      int dcyc, cyc, dones, d1, d2;
      bit stall_seen;

      reset_n     = 1'b0;
      tick        = 1'b0;
      cfg_we      = 1'b0;
      cfg_addr    = '0;
      cfg_current = '0;
      ev_ready    = 1'b0;
      n_pushed    = 0;
      n_seen      = 0;
      model_reset();
      step();
      step();
      reset_n = 1'b1;

      // Reset state, idle for 10 cycles
      for (int c = 0; c < 10; c++) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_overrun", overrun, 0);
         chk("rst_ev_valid", ev_valid, 0);
         step();
      end
      compare_state("rst");
      chk("rst_v0_const", dut.v_q[0], -8320);

      // One sweep with zero currents: done at cycle 8, no events
      ev_ready = 1'b1;
      run_sweep("sw0", dcyc);
      chk("sw0_done_cycle", dcyc, 8);
      chk("sw0_no_events", n_seen, 0);
      compare_state("sw0");
      chk("sw0_v0_hand", dut.v_q[0], -8959);
      chk("sw0_u0_hand", dut.u_q[0], -86);

      // Neuron 2 driven hard; only it spikes, v resets to C after each spike
      set_cur(2, 255);
      n_pushed = 0;
      n_seen   = 0;
      for (int s = 0; s < 6; s++) begin
         run_sweep("drv", dcyc);
         compare_state("drv");
         if (mspk[2]) chk("drv_v2_reset", dut.v_q[2], -8320);
      end
      chk("drv_event_count", n_seen, n_pushed);
      chk("drv_queue_empty", exp_id.size(), 0);

      // All currents high with consumer stalled: FIFO fills, FSM stalls
      ev_ready = 1'b0;
      set_cur(0, 255);
      set_cur(1, 255);
      set_cur(3, 255);
      stall_seen = 1'b0;
      for (int s = 0; s < 8 && !stall_seen; s++) begin
         model_sweep();
         tick = 1'b1;
         step();
         tick = 1'b0;
         cyc = 0;
         if (exp_id.size() > 4) begin
            stall_seen = 1'b1;
            while ((dut.state_q != ST_STALL) && cyc < 100) begin
               step();
               cyc++;
            end
            chk("fill_reach_stall", int'(dut.state_q == ST_STALL), 1);
            chk("fill_busy", busy, 1);
            chk("fill_ev_valid", ev_valid, 1);
            chk("fill_count", dut.count_q, 4);
            repeat (5) step();
            chk("fill_hold_stall", int'(dut.state_q == ST_STALL), 1);
            chk("fill_hold_busy", busy, 1);
            chk("fill_no_done", done, 0);
            ev_ready = 1'b1;
            cyc = 0;
            while (!done && cyc < 200) begin
               watch();
               step();
               cyc++;
            end
            chk("fill_done_after_drain", done, 1);
            repeat (8) begin
               watch();
               step();
            end
         end else begin
            while (!done && cyc < 100) begin
               step();
               cyc++;
            end
            chk("fill_sweep_done", done, 1);
            step();
         end
      end
      chk("fill_stall_seen", int'(stall_seen), 1);
      chk("fill_queue_drained", exp_id.size(), 0);
      chk("fill_fifo_empty", ev_valid, 0);
      compare_state("fill");

      // Ticks at cycles 0, 3, 5: pending then overrun, two sweeps
      ev_ready = 1'b1;
      dones = 0;
      d1 = -1;
      d2 = -1;
      for (int c = 0; c < 40; c++) begin
         tick = (c == 0 || c == 3 || c == 5);
         if (done) begin
            dones++;
            if (dones == 1) d1 = c;
            else if (dones == 2) d2 = c;
         end
         if (c == 4) begin
            chk("tk_pending_c4", dut.pending_q, 1);
            chk("tk_overrun_c4", overrun, 0);
         end
         if (c == 6) chk("tk_overrun_c6", overrun, 1);
         step();
      end
      tick = 1'b0;
      chk("tk_done_count", dones, 2);
      chk("tk_done1_cycle", d1, 8);
      chk("tk_done2_cycle", d2, 17);
      chk("tk_overrun_sticky", overrun, 1);
      chk("tk_busy_end", busy, 0);

      // Reset at cycle 4 of a sweep
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      step();
      chk("mr_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_overrun", overrun, 0);
      chk("mr_ev_valid", ev_valid, 0);
      chk("mr_idx", dut.idx_q, 0);
      chk("mr_sweep", dut.sweep_q, 0);
      chk("mr_v1", dut.v_q[1], -8320);
      chk("mr_cur2", dut.cur_q[2], 0);
      step();
      reset_n = 1'b1;
      model_reset();
      step();
      n_seen = 0;
      run_sweep("post", dcyc);
      chk("post_done_cycle", dcyc, 8);
      chk("post_no_events", n_seen, 0);
      compare_state("post");
      chk("post_v3_hand", dut.v_q[3], -8959);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
